register_bank: RTL and testbench

//  Architectural register file between writeback and decode/operand-fetch: 16x32 GPRs (r15 = PC) plus CPSR.

---
 rtl/arm_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 53 +++++
 rtl/register_bank.sv | 177 +++++++++++++++++
 tb/tb_register_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style register bank: widths, well-known
// register addresses and the operand-read FSM state encoding.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int AW     = $clog2(NREGS);

  localparam logic [AW-1:0] REG_PC = 4'd15;
  localparam logic [AW-1:0] REG_LR = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    STALL = 2'd2
  } rdState_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. A lock (set) and a
// commit (clear) on the same register in the same cycle leaves the bit set,
// because the lock belongs to the newer instruction. The hazard output
// already accounts for a clear landing this cycle, so a reader may capture
// alongside the commit that releases its source.
module reg_scoreboard #(
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             setEn,
  input  logic [AW-1:0]    setAddr,
  input  logic             clrEn,
  input  logic [AW-1:0]    clrAddr,
  input  logic [AW-1:0]    addrA,
  input  logic [AW-1:0]    addrB,
  input  logic [AW-1:0]    addrC,
  output logic [NREGS-1:0] busy,
  output logic             hazard
);

  logic [NREGS-1:0] busyReg;
  logic [NREGS-1:0] busyNext;
  logic [NREGS-1:0] setHit;
  logic [NREGS-1:0] clrHit;
  logic [NREGS-1:0] pending;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : gBusyBit
      assign setHit[gi]   = setEn && (setAddr == AW'(gi));
      assign clrHit[gi]   = clrEn && (clrAddr == AW'(gi));
      // Set beats clear: the re-locking instruction is the new owner.
      assign busyNext[gi] = setHit[gi] | (busyReg[gi] & ~clrHit[gi]);
    end
  endgenerate

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyReg <= '0;
    end else begin
      busyReg <= busyNext;
    end
  end

  // A register being committed this cycle is no longer a hazard.
  assign pending = busyReg & ~clrHit;
  assign hazard  = pending[addrA] | pending[addrB] | pending[addrC];
  assign busy    = busyReg;

endmodule

// File: rtl/register_bank.sv
// Architectural register file: 16 GPRs (top register is the PC) plus CPSR.
// Writeback commits are applied every cycle they are offered; decode reads
// three operands through a small FSM that waits on the pending-write
// scoreboard and forwards a same-cycle commit into the captured operands.
module register_bank #(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 16,
  parameter logic [DATA_W-1:0] PC_INC   = 32'd4,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic              wbRegWe,
  input  logic [AW-1:0]     wbAddr,
  input  logic [DATA_W-1:0] wbData,
  input  logic              wbCpsrWe,
  input  logic [DATA_W-1:0] wbCpsr,
  input  logic              rdReq,
  input  logic [AW-1:0]     rdAddrA,
  input  logic [AW-1:0]     rdAddrB,
  input  logic [AW-1:0]     rdAddrC,
  input  logic              rdLockWe,
  input  logic [AW-1:0]     rdLockAddr,
  output logic              rdAck,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  output logic [DATA_W-1:0] rdDataC,
  input  logic              pcIncr,
  output logic [DATA_W-1:0] pcOut,
  output logic [DATA_W-1:0] cpsrOut,
  output logic [NREGS-1:0]  busyOut
);

  import arm_pkg::*;

  localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] cpsrReg;
  logic [NREGS-1:0]  regWe;
  logic              wbCommit;
  logic              wbRegWrite;

  rdState_e          stateReg;
  rdState_e          stateNext;
  logic              capture;
  logic              hazard;
  logic              lockSet;
  logic [DATA_W-1:0] fwdA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] fwdC;

  // The bank always has room for a commit, so writeback never stalls.
  assign wbReady    = 1'b1;
  assign wbCommit   = wbValid & wbReady;
  assign wbRegWrite = wbCommit & wbRegWe;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : gWeDecode
      assign regWe[gi] = wbRegWrite && (wbAddr == AW'(gi));
    end
  endgenerate

  // Register array; a commit to the PC takes priority over pcIncr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[PC_ADDR] <= RESET_PC;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (regWe[i]) begin
          regs[i] <= wbData;
        end
      end
      if (regWe[PC_ADDR]) begin
        regs[PC_ADDR] <= wbData;
      end else if (pcIncr) begin
        regs[PC_ADDR] <= regs[PC_ADDR] + PC_INC;
      end
    end
  end

  // CPSR is written only by commits; it is not tracked by the scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpsrReg <= '0;
    end else if (wbCommit && wbCpsrWe) begin
      cpsrReg <= wbCpsr;
    end
  end

  assign pcOut   = regs[PC_ADDR];
  assign cpsrOut = cpsrReg;

  // Operand bypass: a commit landing in the capture cycle wins over the array.
  // The PC source sees a same-cycle commit but not a same-cycle pcIncr.
  assign fwdA = (wbRegWrite && (wbAddr == rdAddrA)) ? wbData : regs[rdAddrA];
  assign fwdB = (wbRegWrite && (wbAddr == rdAddrB)) ? wbData : regs[rdAddrB];
  assign fwdC = (wbRegWrite && (wbAddr == rdAddrC)) ? wbData : regs[rdAddrC];

  assign lockSet = capture & rdLockWe;

  reg_scoreboard #(
    .NREGS(NREGS)
  ) uScoreboard (
    .clk    (clk),
    .reset  (reset),
    .setEn  (lockSet),
    .setAddr(rdLockAddr),
    .clrEn  (wbCommit),
    .clrAddr(wbAddr),
    .addrA  (rdAddrA),
    .addrB  (rdAddrB),
    .addrC  (rdAddrC),
    .busy   (busyOut),
    .hazard (hazard)
  );

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Read FSM next state: wait for all sources clear, then capture once.
  always_comb begin
    stateNext = stateReg;
    capture   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (rdReq) begin
          stateNext = CHECK;
        end
      end
      CHECK, STALL: begin
        if (!rdReq) begin
          stateNext = IDLE;
        end else if (hazard) begin
          stateNext = STALL;
        end else begin
          capture   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Operand capture and the one-cycle acknowledge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdAck   <= 1'b0;
      rdDataA <= '0;
      rdDataB <= '0;
      rdDataC <= '0;
    end else begin
      rdAck <= capture;
      if (capture) begin
        rdDataA <= fwdA;
        rdDataB <= fwdB;
        rdDataC <= fwdC;
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: expected operand values are queued when
// a read is issued and compared when the acknowledge arrives.
module tb_register_bank;

  logic        clk;
  logic        reset;
  logic        wbValid;
  logic        wbReady;
  logic        wbRegWe;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;
  logic        wbCpsrWe;
  logic [31:0] wbCpsr;
  logic        rdReq;
  logic [3:0]  rdAddrA;
  logic [3:0]  rdAddrB;
  logic [3:0]  rdAddrC;
  logic        rdLockWe;
  logic [3:0]  rdLockAddr;
  logic        rdAck;
  logic [31:0] rdDataA;
  logic [31:0] rdDataB;
  logic [31:0] rdDataC;
  logic        pcIncr;
  logic [31:0] pcOut;
  logic [31:0] cpsrOut;
  logic [15:0] busyOut;

  int nAsserts = 0;
  int nFail    = 0;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } expRead_t;

  expRead_t expQ[$];

  register_bank dut (
    .clk       (clk),
    .reset     (reset),
    .wbValid   (wbValid),
    .wbReady   (wbReady),
    .wbRegWe   (wbRegWe),
    .wbAddr    (wbAddr),
    .wbData    (wbData),
    .wbCpsrWe  (wbCpsrWe),
    .wbCpsr    (wbCpsr),
    .rdReq     (rdReq),
    .rdAddrA   (rdAddrA),
    .rdAddrB   (rdAddrB),
    .rdAddrC   (rdAddrC),
    .rdLockWe  (rdLockWe),
    .rdLockAddr(rdLockAddr),
    .rdAck     (rdAck),
    .rdDataA   (rdDataA),
    .rdDataB   (rdDataB),
    .rdDataC   (rdDataC),
    .pcIncr    (pcIncr),
    .pcOut     (pcOut),
    .cpsrOut   (cpsrOut),
    .busyOut   (busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One commit cycle, driven from a falling edge; returns on the next one.
  task automatic commit(input logic [3:0] addr, input logic [31:0] data,
                        input logic regWe, input logic cpsrWe, input logic [31:0] cpsr);
    wbValid  = 1'b1;
    wbAddr   = addr;
    wbData   = data;
    wbRegWe  = regWe;
    wbCpsrWe = cpsrWe;
    wbCpsr   = cpsr;
    @(negedge clk);
    wbValid  = 1'b0;
    wbRegWe  = 1'b0;
    wbCpsrWe = 1'b0;
    $display("commit r%0d=%h regWe=%0b cpsrWe=%0b cpsr=%h pcIncr=%0b -> pc=%h cpsr=%h busy=%h",
             addr, data, regWe, cpsrWe, cpsr, pcIncr, pcOut, cpsrOut, busyOut);
  endtask

  // Hazard-free read: expects the acknowledge two cycles after the request.
  task automatic doRead(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic lockWe, input logic [3:0] lockAddr,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
    expRead_t e;
    int cycles;
    e.tag = tag;
    e.a   = ea;
    e.b   = eb;
    e.c   = ec;
    expQ.push_back(e);
    rdAddrA    = a;
    rdAddrB    = b;
    rdAddrC    = c;
    rdLockWe   = lockWe;
    rdLockAddr = lockAddr;
    rdReq      = 1'b1;
    cycles     = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!rdAck && cycles < 20);
    rdReq    = 1'b0;
    rdLockWe = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'd2);
    e = expQ.pop_front();
    check({e.tag, "_A"}, rdDataA, e.a);
    check({e.tag, "_B"}, rdDataB, e.b);
    check({e.tag, "_C"}, rdDataC, e.c);
    $display("read %s A=r%0d:%h B=r%0d:%h C=r%0d:%h lock=%0b/r%0d latency=%0d busy=%h",
             tag, a, rdDataA, b, rdDataB, c, rdDataC, lockWe, lockAddr, cycles, busyOut);
  endtask

  initial begin
    reset      = 1'b1;
    wbValid    = 1'b0;
    wbRegWe    = 1'b0;
    wbAddr     = '0;
    wbData     = '0;
    wbCpsrWe   = 1'b0;
    wbCpsr     = '0;
    rdReq      = 1'b0;
    rdAddrA    = '0;
    rdAddrB    = '0;
    rdAddrC    = '0;
    rdLockWe   = 1'b0;
    rdLockAddr = '0;
    pcIncr     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rdAck", 32'(rdAck), 32'd0);
    check("rst_busy", 32'(busyOut), 32'd0);
    check("rst_pc", pcOut, 32'h0);
    check("rst_cpsr", cpsrOut, 32'h0);
    check("rst_wbReady", 32'(wbReady), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // 1: first read after reset
    doRead("t1", 4'd15, 4'd0, 4'd1, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    check("t1_busy", 32'(busyOut), 32'd0);

    // 2: commit and read back; CPSR unaffected by a register write
    commit(4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    check("t2_cpsr", cpsrOut, 32'h0);
    doRead("t2", 4'd3, 4'd3, 4'd0, 1'b0, 4'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    commit(4'd3, 32'h1234_5678, 1'b0, 1'b1, 32'hA000_0005);
    check("t2_cpsrWrite", cpsrOut, 32'hA000_0005);
    doRead("t2b", 4'd0, 4'd3, 4'd3, 1'b1, 4'd3, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    check("t2_lock3", 32'(busyOut), 32'h0008);
    commit(4'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    check("t2_noopClears", 32'(busyOut), 32'h0000);
    check("t2_noopCpsr", cpsrOut, 32'hA000_0005);

    // 3: lock r5, stall on it, release with a bypassed commit
    doRead("t3lock", 4'd0, 4'd1, 4'd2, 1'b1, 4'd5, 32'h0, 32'h0, 32'h0);
    check("t3_busy5", 32'(busyOut), 32'h0020);
    rdAddrA = 4'd5;
    rdAddrB = 4'd3;
    rdAddrC = 4'd0;
    rdReq   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_stallNoAck", 32'(rdAck), 32'd0);
    end
    wbValid = 1'b1;
    wbRegWe = 1'b1;
    wbAddr  = 4'd5;
    wbData  = 32'h55;
    @(negedge clk);
    wbValid = 1'b0;
    wbRegWe = 1'b0;
    rdReq   = 1'b0;
    check("t3_ack", 32'(rdAck), 32'd1);
    check("t3_bypassA", rdDataA, 32'h55);
    check("t3_B", rdDataB, 32'hDEADBEEF);
    check("t3_busyClear", 32'(busyOut), 32'h0);
    $display("read t3stall A=r5:%h B=r3:%h busy=%h", rdDataA, rdDataB, busyOut);
    @(negedge clk);
    check("t3_ackPulse", 32'(rdAck), 32'd0);
    doRead("t3r5", 4'd5, 4'd0, 4'd5, 1'b0, 4'd0, 32'h55, 32'h0, 32'h55);

    // 4: commit clear of r7 coincident with an acked lock of r7
    rdAddrA    = 4'd0;
    rdAddrB    = 4'd3;
    rdAddrC    = 4'd5;
    rdLockWe   = 1'b1;
    rdLockAddr = 4'd7;
    rdReq      = 1'b1;
    @(negedge clk);
    wbValid = 1'b1;
    wbRegWe = 1'b1;
    wbAddr  = 4'd7;
    wbData  = 32'h77;
    @(negedge clk);
    wbValid  = 1'b0;
    wbRegWe  = 1'b0;
    rdReq    = 1'b0;
    rdLockWe = 1'b0;
    check("t4_ack", 32'(rdAck), 32'd1);
    check("t4_setWins", 32'(busyOut), 32'h0080);
    $display("read t4 lock r7 with coincident commit busy=%h", busyOut);
    commit(4'd7, 32'h78, 1'b1, 1'b0, 32'h0);
    check("t4_release", 32'(busyOut), 32'h0);
    doRead("t4r7", 4'd7, 4'd7, 4'd3, 1'b0, 4'd0, 32'h78, 32'h78, 32'hDEADBEEF);

    // 5: PC wrap and commit-over-increment priority
    commit(4'd15, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    check("t5_pcWrite", pcOut, 32'hFFFF_FFFC);
    pcIncr = 1'b1;
    @(negedge clk);
    pcIncr = 1'b0;
    check("t5_wrap", pcOut, 32'h0);
    $display("pcIncr -> pc=%h", pcOut);
    pcIncr = 1'b1;
    commit(4'd15, 32'h100, 1'b1, 1'b0, 32'h0);
    pcIncr = 1'b0;
    check("t5_commitWins", pcOut, 32'h100);
    pcIncr = 1'b1;
    @(negedge clk);
    pcIncr = 1'b0;
    check("t5_incr", pcOut, 32'h104);
    $display("pcIncr -> pc=%h", pcOut);
    doRead("t5pc", 4'd15, 4'd3, 4'd15, 1'b0, 4'd0, 32'h104, 32'hDEADBEEF, 32'h104);

    // 6: async reset while stalled on r9
    doRead("t6lock", 4'd15, 4'd3, 4'd7, 1'b1, 4'd9, 32'h104, 32'hDEADBEEF, 32'h78);
    check("t6_busy9", 32'(busyOut), 32'h0200);
    rdAddrA = 4'd9;
    rdAddrB = 4'd0;
    rdAddrC = 4'd0;
    rdReq   = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_stalled", 32'(rdAck), 32'd0);
    #2;
    reset = 1'b1;
    rdReq = 1'b0;
    #1;
    check("t6_rstAck", 32'(rdAck), 32'd0);
    check("t6_rstA", rdDataA, 32'h0);
    check("t6_rstB", rdDataB, 32'h0);
    check("t6_rstC", rdDataC, 32'h0);
    check("t6_rstBusy", 32'(busyOut), 32'h0);
    check("t6_rstPc", pcOut, 32'h0);
    check("t6_rstCpsr", cpsrOut, 32'h0);
    $display("async reset during stall: rdAck=%0b busy=%h pc=%h", rdAck, busyOut, pcOut);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_noAck", 32'(rdAck), 32'd0);
    end
    doRead("t6r9", 4'd9, 4'd3, 4'd15, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    check("t6_busyEnd", 32'(busyOut), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
